// File: rtl/result_checker_pkg.sv
// Shared types and helpers for the pipelined-MIPS result checker.
package result_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_BEGIN = 2'd1,
        ST_CHECK      = 2'd2,
        ST_REPORT     = 2'd3
    } state_e;

    localparam logic [7:0]  ERR_NOT_RUN = 8'hFF;
    localparam logic [7:0]  ERR_MAX     = 8'hFF;
    localparam logic [15:0] DUR_MAX     = 16'hFFFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == ERR_MAX) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == DUR_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/result_checker_if.sv
// Data-memory write bus plus expected-table load port seen by the checker.
interface result_checker_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wen;
    logic              exp_we;
    logic [7:0]        exp_idx;
    logic [DATA_W-1:0] exp_data;

    modport master (
        output addr, data, wen, exp_we, exp_idx, exp_data
    );

    modport slave (
        input addr, data, wen, exp_we, exp_idx, exp_data
    );
endinterface

// File: rtl/result_exp_mem.sv
// Expected-result table: one write port, one asynchronous read port, no reset.
module result_exp_mem #(
    parameter int DATA_W     = 32,
    parameter int NUM_CHECKS = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [7:0]        wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [7:0]        rd_idx,
    output logic [DATA_W-1:0] rd_data
);
    localparam int         AW    = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam logic [7:0] NUM_W = 8'(NUM_CHECKS);

    logic [DATA_W-1:0] mem_q [NUM_CHECKS];

    // Out-of-range indices are dropped so they cannot alias onto a low entry.
    always_ff @(posedge clk) begin
        if (we && (wr_idx < NUM_W)) begin
            mem_q[wr_idx[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = (rd_idx < NUM_W) ? mem_q[rd_idx[AW-1:0]] : '0;

endmodule

// File: rtl/result_checker.sv
// Store monitor: edge-detects writes to the test port, compares them against
// the expected table, counts mismatches and cycles, and raises finish.
module result_checker
    import result_checker_pkg::*;
#(
    parameter int          ADDR_W       = 30,
    parameter int          DATA_W       = 32,
    parameter int          NUM_CHECKS   = 13,
    parameter logic [29:0] TEST_ADDR    = 30'h40,
    parameter bit          BEGIN_EN     = 1'b1,
    parameter logic [31:0] BEGIN_SYMBOL = 32'h0000_0932,
    parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    result_checker_if.slave   bus,
    output logic [7:0]        error_num,
    output logic [15:0]       duration,
    output logic              finish,
    output logic              timeout,
    output logic              err_valid,
    output logic [7:0]        first_err_idx,
    output logic [DATA_W-1:0] first_err_got,
    output logic [DATA_W-1:0] first_err_exp
);
    localparam logic [7:0] NUM_W = 8'(NUM_CHECKS);

    state_e            state_q, state_d;
    logic              wen_q;
    logic [7:0]        error_num_q, error_num_d;
    logic [15:0]       duration_q, duration_d;
    logic [7:0]        idx_q, idx_d;
    logic              timeout_q, timeout_d;
    logic              err_valid_q, err_valid_d;
    logic [7:0]        ferr_idx_q, ferr_idx_d;
    logic [DATA_W-1:0] ferr_got_q, ferr_got_d;
    logic [DATA_W-1:0] ferr_exp_q, ferr_exp_d;
    logic [DATA_W-1:0] exp_rd;
    logic              accept;
    logic              is_begin;

    result_exp_mem #(
        .DATA_W     (DATA_W),
        .NUM_CHECKS (NUM_CHECKS)
    ) u_exp_mem (
        .clk     (clk),
        .we      (bus.exp_we),
        .wr_idx  (bus.exp_idx),
        .wr_data (bus.exp_data),
        .rd_idx  (idx_q),
        .rd_data (exp_rd)
    );

    // A store held across a D-cache stall is accepted only on its first cycle.
    assign accept   = bus.wen && !wen_q && (bus.addr == ADDR_W'(TEST_ADDR));
    assign is_begin = (bus.data == DATA_W'(BEGIN_SYMBOL));

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wen_q       <= 1'b0;
            error_num_q <= ERR_NOT_RUN;
            duration_q  <= '0;
            idx_q       <= '0;
            timeout_q   <= 1'b0;
            err_valid_q <= 1'b0;
            ferr_idx_q  <= '0;
            ferr_got_q  <= '0;
            ferr_exp_q  <= '0;
        end else begin
            state_q     <= state_d;
            wen_q       <= bus.wen;
            error_num_q <= error_num_d;
            duration_q  <= duration_d;
            idx_q       <= idx_d;
            timeout_q   <= timeout_d;
            err_valid_q <= err_valid_d;
            ferr_idx_q  <= ferr_idx_d;
            ferr_got_q  <= ferr_got_d;
            ferr_exp_q  <= ferr_exp_d;
        end
    end

    // Next-state logic; timeout wins over a store arriving in the same cycle.
    always_comb begin
        state_d     = state_q;
        error_num_d = error_num_q;
        duration_d  = duration_q;
        idx_d       = idx_q;
        timeout_d   = timeout_q;
        err_valid_d = err_valid_q;
        ferr_idx_d  = ferr_idx_q;
        ferr_got_d  = ferr_got_q;
        ferr_exp_d  = ferr_exp_q;

        case (state_q)
            ST_IDLE: begin
                error_num_d = '0;
                duration_d  = '0;
                idx_d       = '0;
                err_valid_d = 1'b0;
                state_d     = BEGIN_EN ? ST_WAIT_BEGIN : ST_CHECK;
            end
            ST_WAIT_BEGIN: begin
                if (duration_q == TIMEOUT) begin
                    state_d   = ST_REPORT;
                    timeout_d = 1'b1;
                end else begin
                    duration_d = sat_inc16(duration_q);
                    if (accept && is_begin) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (duration_q == TIMEOUT) begin
                    state_d   = ST_REPORT;
                    timeout_d = 1'b1;
                end else begin
                    duration_d = sat_inc16(duration_q);
                    if (accept) begin
                        if (bus.data != exp_rd) begin
                            error_num_d = sat_inc8(error_num_q);
                            if (!err_valid_q) begin
                                err_valid_d = 1'b1;
                                ferr_idx_d  = idx_q;
                                ferr_got_d  = bus.data;
                                ferr_exp_d  = exp_rd;
                            end
                        end
                        idx_d = idx_q + 8'd1;
                        if ((idx_q + 8'd1) == NUM_W) begin
                            state_d = ST_REPORT;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_REPORT;
            end
        endcase
    end

    assign error_num     = error_num_q;
    assign duration      = duration_q;
    assign finish        = (state_q == ST_REPORT);
    assign timeout       = timeout_q;
    assign err_valid     = err_valid_q;
    assign first_err_idx = ferr_idx_q;
    assign first_err_got = ferr_got_q;
    assign first_err_exp = ferr_exp_q;

endmodule
